// File: rtl/cache_mem_ctrl_pkg.sv
// cache_mem_ctrl_pkg: shared types for the cache-side memory controller
package cache_mem_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [2:0] {IDLE, DBUSY, IBUSY, DDONE, IDONE} memctrl_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_mem_ctrl.sv
// cache_mem_ctrl: arbitrates icache/dcache word accesses onto a fixed-latency RAM
module cache_mem_ctrl
  import cache_mem_ctrl_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  iREN,
  input  word_t iaddr,
  output logic  iwait,
  output word_t iload,
  input  logic  dREN,
  input  logic  dWEN,
  input  word_t daddr,
  input  word_t dstore,
  output logic  dwait,
  output word_t dload,
  output logic  ramREN,
  output logic  ramWEN,
  output word_t ramaddr,
  output word_t ramstore,
  input  word_t ramload
);
  localparam int CW = $clog2(LAT + 1);
  memctrl_state_t state, next_state;
  grant_t last_grant;
  logic [CW-1:0] cnt, next_cnt;
  word_t addr_q, store_q, buf_q;
  logic wr_q, dreq, pick_d, busy, abort, last;
  assign dreq = dREN | dWEN;
  assign pick_d = dreq & (~iREN | (last_grant == GRANT_I));
  assign busy = (state == DBUSY) | (state == IBUSY);
  assign last = cnt == CW'(LAT - 1);
  // the granted initiator must hold enable, address and op for the whole access
  assign abort = (state == DBUSY) ? (~dreq | (daddr != addr_q) | (dWEN != wr_q)) :
                 (state == IBUSY) ? (~iREN | (iaddr != addr_q)) : 1'b0;
  always_comb begin
    next_state = state;
    next_cnt = '0;
    if (state == IDLE) next_state = pick_d ? DBUSY : iREN ? IBUSY : IDLE;
    else if (busy) begin
      next_cnt = cnt + 1'b1;
      next_state = abort ? IDLE : !last ? state : (state == DBUSY) ? DDONE : IDONE;
    end else next_state = IDLE;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= next_state;
      cnt <= next_cnt;
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      addr_q <= '0;
      store_q <= '0;
      wr_q <= 1'b0;
      buf_q <= '0;
      last_grant <= GRANT_D;
    end else if ((state == IDLE) & (dreq | iREN)) begin
      addr_q <= pick_d ? daddr : iaddr;
      store_q <= pick_d ? dstore : store_q;
      wr_q <= pick_d & dWEN;
      last_grant <= pick_d ? GRANT_D : GRANT_I;
    end else if (busy & last & ~abort & ~wr_q) buf_q <= ramload;
  assign ramREN = busy & ~wr_q & ~abort;
  assign ramWEN = busy & wr_q & ~abort;
  assign ramaddr = addr_q;
  assign ramstore = store_q;
  assign iwait = state != IDONE;
  assign dwait = state != DDONE;
  assign iload = buf_q;
  assign dload = buf_q;
endmodule

// File: tb/tb_cache_mem_ctrl.sv
// tb_cache_mem_ctrl: randomized cache traffic against a transaction-level timing/data model
module tb_cache_mem_ctrl;
  localparam int LAT = 2;
  logic CLK = 1'b0, nRST = 1'b0;
  logic iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0;
  logic iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore, ramload;
  int total = 0, bad = 0;

  cache_mem_ctrl #(.LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] init_word(input int k);
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // RAM: data only valid in the last enabled cycle; writes commit at its end
  logic [31:0] ram [256];
  bit [255:0] written;
  int en_cnt = 0;
  logic [7:0] ridx;
  assign ridx = ramaddr[9:2];
  assign ramload = (en_cnt == LAT - 1) ? (written[ridx] ? ram[ridx] : init_word(int'(ridx))) : 32'hBAD0_0BAD;
  always @(posedge CLK) begin
    if (ramREN || ramWEN) begin
      if (ramWEN && en_cnt == LAT - 1) begin
        ram[ridx] <= ramstore;
        written[ridx] <= 1'b1;
      end
      en_cnt <= en_cnt + 1;
    end else en_cnt <= 0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic wr;
    logic both;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  function automatic req_t mk(input logic wr, input logic both, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.wr = wr; r.both = both; r.addr = a; r.data = d;
    return r;
  endfunction

  req_t iq[$], dq[$];
  req_t icur, dcur;
  logic iact = 0, dact = 0, idone = 0, ddone = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] buf_m = '0;
  int cyc = 0, free_at = 0, g_cyc = 0;
  logic pend = 0, last_d = 1, g_d = 0, g_wr = 0;
  logic [31:0] g_addr = '0, g_data = '0;

  // one clock of the transaction-level model: each grant owns LAT busy cycles then one done cycle
  task automatic model_cycle();
    logic busy, done;
    busy = pend && cyc > g_cyc && cyc <= g_cyc + LAT;
    done = pend && cyc == g_cyc + LAT + 1;
    if (done) begin
      if (g_wr) ref_mem[g_addr[9:2]] = g_data;
      else buf_m = ref_mem[g_addr[9:2]];
      if (g_d) ddone = 1; else idone = 1;
      pend = 0;
    end
    chk("iwait", iwait, !(done && !g_d));
    chk("dwait", dwait, !(done && g_d));
    chk("ramREN", ramREN, busy && !g_wr);
    chk("ramWEN", ramWEN, busy && g_wr);
    chk("iload", iload, buf_m);
    chk("dload", dload, buf_m);
    if (busy) chk("ramaddr", ramaddr, g_addr);
    if (busy && g_wr) chk("ramstore", ramstore, g_data);
    if (cyc >= free_at && (dREN || dWEN || iREN)) begin
      g_d = (dREN || dWEN) && (!iREN || !last_d);
      last_d = g_d;
      g_cyc = cyc;
      free_at = cyc + LAT + 2;
      pend = 1;
      g_wr = g_d && dWEN;
      g_addr = g_d ? daddr : iaddr;
      g_data = dstore;
    end
  endtask

  task automatic run(input int n);
    int k = 0;
    while ((k < n || iq.size() > 0 || dq.size() > 0 || iact || dact || pend) && k < n + 400) begin
      @(posedge CLK); #1;
      if (k < n && iq.size() == 0 && $urandom_range(0, 3) == 0)
        iq.push_back(mk(0, 0, {22'd0, 8'($urandom_range(0, 63)), 2'b00}, 32'd0));
      if (k < n && dq.size() == 0 && $urandom_range(0, 2) == 0)
        dq.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        {22'd0, 8'($urandom_range(0, 63)), 2'b00}, $urandom));
      if (idone) iact = 0;
      if (ddone) dact = 0;
      idone = 0;
      ddone = 0;
      if (!iact && iq.size() > 0) begin icur = iq.pop_front(); iact = 1; end
      if (!dact && dq.size() > 0) begin dcur = dq.pop_front(); dact = 1; end
      iREN = iact;
      iaddr = icur.addr;
      dREN = dact && (!dcur.wr || dcur.both);
      dWEN = dact && dcur.wr;
      daddr = dcur.addr;
      dstore = dcur.data;
      @(negedge CLK);
      model_cycle();
      cyc++;
      k++;
    end
    if (k >= n + 400) chk("drain", 32'd0, 32'd1);
  endtask

  task automatic xact(input logic d, input logic wr, input logic [31:0] a, input logic [31:0] s,
                      output int lat, output logic [31:0] got);
    lat = -1;
    got = '0;
    iREN = !d; iaddr = a; dREN = d && !wr; dWEN = d && wr; daddr = a; dstore = s;
    for (int k = 0; k < 20 && lat < 0; k++) begin
      @(negedge CLK);
      if (!(d ? dwait : iwait)) begin
        lat = k;
        got = d ? dload : iload;
      end else begin
        @(posedge CLK); #1;
      end
    end
    @(posedge CLK); #1;
    iREN = 0; dREN = 0; dWEN = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] got;
    for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
    #12;
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_iload", iload, 0);
    chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_ramstore", ramstore, 0);
    @(negedge CLK);
    nRST = 1;
    dq.push_back(mk(1, 0, 32'h40, 32'hDEADBEEF));
    dq.push_back(mk(0, 0, 32'h40, 0));
    dq.push_back(mk(1, 0, 32'h48, 32'h12345678));
    dq.push_back(mk(0, 0, 32'h48, 0));
    run(0);
    for (int k = 0; k < 3; k++) begin
      iq.push_back(mk(0, 0, 32'(k * 4), 0));
      dq.push_back(mk(0, 0, 32'h100 + 32'(k * 4), 0));
    end
    run(0);
    dq.push_back(mk(1, 0, 32'h80, 32'h0BADF00D));
    dq.push_back(mk(1, 1, 32'h84, 32'h600DCAFE));
    iq.push_back(mk(0, 0, 32'h0C, 0));
    run(0);
    run(600);
    // abort: write granted, then dropped in its first busy cycle
    @(posedge CLK); #1;
    dWEN = 1; daddr = 32'h60; dstore = 32'hA5A5A5A5;
    @(posedge CLK); #1;
    dWEN = 0;
    @(negedge CLK);
    chk("abort_ramWEN", ramWEN, 0);
    chk("abort_dwait", dwait, 1);
    @(posedge CLK); #1;
    xact(1, 0, 32'h60, 0, lat, got);
    chk("abort_lat", 32'(lat), LAT + 1);
    chk("abort_data", got, ref_mem[8'h18]);
    // async reset in the middle of a write
    @(posedge CLK); #1;
    dWEN = 1; daddr = 32'h70; dstore = 32'hCAFEF00D;
    @(posedge CLK); #2;
    chk("pre_rst_ramWEN", ramWEN, 1);
    nRST = 0;
    #1;
    chk("arst_ramWEN", ramWEN, 0);
    chk("arst_ramREN", ramREN, 0);
    chk("arst_dwait", dwait, 1);
    chk("arst_iwait", iwait, 1);
    chk("arst_dload", dload, 0);
    chk("arst_iload", iload, 0);
    chk("arst_ramaddr", ramaddr, 0);
    chk("arst_ramstore", ramstore, 0);
    dWEN = 0;
    @(negedge CLK);
    nRST = 1;
    @(posedge CLK); #1;
    xact(0, 0, 32'h70, 0, lat, got);
    chk("post_rst_lat", 32'(lat), LAT + 1);
    chk("post_rst_data", got, ref_mem[8'h1C]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
